ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS integer pipeline. It captures the execute result (destination register, write enable, write data, HI/LO write request) on every unstalled clock edge. It honours the pipeline stall vector by holding its contents or inserting a bubble, and clears on flush. It also stores the two-cycle multiply-accumulate partial result and cycle counter, and feeds them back to execute while execute is stalled.

---
 rtl/ex_mem.sv | 121 ++++++++++++
 tb/tb_ex_mem.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with stall, bubble, flush and multiply-accumulate feedback
//
// Captures the execute-stage result on every unstalled rising edge and presents
// it to the memory-access stage one clock later.
//
// Optional feature macro: EX_MEM_MADD_EN
//   defined     : hilo_o/cnt_o feedback registers hold the multiply-accumulate
//                 partial product and cycle counter while execute is stalled.
//   not defined : hilo_o and cnt_o are constant 0; hilo_i and cnt_i are unused.
//
// Ports:
//   clk        pipeline clock, all state updates on rising edge
//   rst        asynchronous active-low reset
//   stall      stall vector; bit 3 = execute stalled, bit 4 = memory stalled
//   flush      synchronous exception flush (highest priority after reset)
//   ex_wd      destination register from execute
//   ex_wreg    register write enable from execute
//   ex_wdata   register write data from execute
//   ex_whilo   HI/LO write enable from execute
//   ex_hi      HI write value from execute
//   ex_lo      LO write value from execute
//   hilo_i     multiply-accumulate partial product from execute
//   cnt_i      execute multi-cycle counter
//   mem_wd     registered destination register
//   mem_wreg   registered write enable
//   mem_wdata  registered write data
//   mem_whilo  registered HI/LO write enable
//   mem_hi     registered HI value
//   mem_lo     registered LO value
//   hilo_o     partial product fed back to execute
//   cnt_o      counter fed back to execute

module ex_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o
);

    // A memory stall with execute running is an illegal pattern; folding
    // stall[4] into the execute-held term turns it into a plain hold.
    logic ex_held;
    logic mem_held;

    assign ex_held  = stall[3] | stall[4];
    assign mem_held = stall[4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
        end else if (flush || (ex_held && !mem_held)) begin
            // Bubble: memory stage proceeds with a NOP.
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_whilo <= 1'b0;
            mem_hi    <= '0;
            mem_lo    <= '0;
        end else if (!ex_held) begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whilo <= ex_whilo;
            mem_hi    <= ex_hi;
            mem_lo    <= ex_lo;
        end
        // Both stages held: contents unchanged.
    end

`ifdef EX_MEM_MADD_EN
    // Partial product and counter survive only while execute is held, so a
    // two-cycle madd sees its first-cycle result on the second cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else if (flush || !ex_held) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end
    end

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[2:0]};
`else
    assign hilo_o = '0;
    assign cnt_o  = '0;

    logic unused_feedback_in;
    assign unused_feedback_in = ^{stall[5], stall[2:0], hilo_i, cnt_i};
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - self-checking randomized bench for ex_mem against a behavioural model
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int checks   = 0;
    int failures = 0;

    // Expected state of the memory-stage view and feedback path.
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Stimulus must never present a memory stall while execute runs.
    always @(posedge clk) begin
        if (rst && !flush)
            assert (!(stall[4] && !stall[3]))
            else $error("FAIL illegal_stall stall=%b", stall);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        e_wd = 0; e_wreg = 0; e_wdata = 0; e_whilo = 0;
        e_hi = 0; e_lo = 0; e_hilo = 0; e_cnt = 0;
    endtask

    // One rising edge of the stage as described: flush > bubble > hold > capture.
    task automatic model_edge();
        bit ex_stalled;
        bit mem_stalled;
        if (!rst) begin
            model_clear();
            return;
        end
        ex_stalled  = stall[3];
        mem_stalled = stall[4];
        if (!ex_stalled && mem_stalled) ex_stalled = 1'b1;
        if (flush) begin
            model_clear();
            return;
        end
        if (!ex_stalled) begin
            e_wd = ex_wd; e_wreg = ex_wreg; e_wdata = ex_wdata;
            e_whilo = ex_whilo; e_hi = ex_hi; e_lo = ex_lo;
        end else if (!mem_stalled) begin
            e_wd = 0; e_wreg = 0; e_wdata = 0; e_whilo = 0; e_hi = 0; e_lo = 0;
        end
`ifdef EX_MEM_MADD_EN
        e_hilo = ex_stalled ? hilo_i : 64'd0;
        e_cnt  = ex_stalled ? cnt_i  : 2'd0;
`else
        e_hilo = 0;
        e_cnt  = 0;
`endif
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".wd"},    64'(mem_wd),    64'(e_wd));
        chk({ctx, ".wreg"},  64'(mem_wreg),  64'(e_wreg));
        chk({ctx, ".wdata"}, 64'(mem_wdata), 64'(e_wdata));
        chk({ctx, ".whilo"}, 64'(mem_whilo), 64'(e_whilo));
        chk({ctx, ".hi"},    64'(mem_hi),    64'(e_hi));
        chk({ctx, ".lo"},    64'(mem_lo),    64'(e_lo));
        chk({ctx, ".hilo"},  hilo_o,         e_hilo);
        chk({ctx, ".cnt"},   64'(cnt_o),     64'(e_cnt));
    endtask

    // Inputs are set before the call; model advances on the edge, outputs checked at negedge.
    task automatic cyc(input string ctx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic rand_inputs();
        ex_wd    = 5'($urandom);
        ex_wreg  = 1'($urandom);
        ex_wdata = $urandom;
        ex_whilo = 1'($urandom);
        ex_hi    = $urandom;
        ex_lo    = $urandom;
        hilo_i   = {$urandom, $urandom};
        cnt_i    = 2'($urandom);
    endtask

    task automatic rand_stall();
        logic [5:0] s;
        s = 6'($urandom) & 6'b100111;
        case ($urandom_range(0, 2))
            0:       s[4:3] = 2'b00;
            1:       s[4:3] = 2'b01;
            default: s[4:3] = 2'b11;
        endcase
        stall = s;
    endtask

    initial begin
        rst = 1'b0; stall = 0; flush = 0;
        ex_wd = 5'd3; ex_wreg = 1; ex_wdata = 32'hDEADBEEF; ex_whilo = 1;
        ex_hi = 32'h11; ex_lo = 32'h22; hilo_i = 64'h1234; cnt_i = 2'd1;
        model_clear();

        // Reset held while clocking.
        cyc("reset");
        cyc("reset");
        chk("reset_wdata", 64'(mem_wdata), 64'd0);
        chk("reset_wreg",  64'(mem_wreg),  64'd0);
        rst = 1'b1;
        cyc("release");
        chk("release_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("release_wreg",  64'(mem_wreg),  64'd1);

        // Capture.
        ex_wd = 5'd5; ex_wreg = 1; ex_wdata = 32'h00001234;
        cyc("capture");
        chk("capture_wd",    64'(mem_wd),    64'd5);
        chk("capture_wdata", 64'(mem_wdata), 64'h1234);

        // Bubble.
        stall = 6'b001000; ex_wdata = 32'h55;
        cyc("bubble");
        chk("bubble_wreg",  64'(mem_wreg),  64'd0);
        chk("bubble_wdata", 64'(mem_wdata), 64'd0);
        chk("bubble_wd",    64'(mem_wd),    64'd0);

        // Hold for three cycles with changing inputs.
        stall = 0; ex_wdata = 32'hA5A5A5A5; ex_wreg = 1; ex_wd = 5'd9;
        cyc("hold_load");
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cyc("hold");
            chk("hold_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
            chk("hold_wreg",  64'(mem_wreg),  64'd1);
        end

        // Multiply-accumulate feedback.
        stall = 6'b001000; hilo_i = 64'h0000000100000002; cnt_i = 2'd1;
        cyc("madd1");
`ifdef EX_MEM_MADD_EN
        chk("madd_hilo", hilo_o, 64'h0000000100000002);
        chk("madd_cnt",  64'(cnt_o), 64'd1);
`else
        chk("madd_hilo_off", hilo_o, 64'd0);
        chk("madd_cnt_off",  64'(cnt_o), 64'd0);
`endif
        stall = 0;
        cyc("madd2");
        chk("madd_hilo_clr", hilo_o, 64'd0);
        chk("madd_cnt_clr",  64'(cnt_o), 64'd0);

        // Flush beats stall, starting from nonzero outputs and feedback.
        ex_wd = 5'd7; ex_wreg = 1; ex_wdata = 32'hCAFEF00D; ex_whilo = 1;
        cyc("pre_flush");
        stall = 6'b011000; hilo_i = 64'hFFFF; cnt_i = 2'd2;
        cyc("pre_flush_fb");
        flush = 1;
        cyc("flush");
        chk("flush_wdata", 64'(mem_wdata), 64'd0);
        chk("flush_hilo",  hilo_o,         64'd0);
        chk("flush_cnt",   64'(cnt_o),     64'd0);
        flush = 0; stall = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rand_stall();
            flush = ($urandom_range(0, 15) == 0);
            cyc("rand");
            // Occasional asynchronous reset between edges.
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_clear();
                check_all("async_reset");
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
